seq_detect_ctrl: RTL
====================

Name: seq_detect_ctrl

Overview:
Run controller for a programmable serial Moore pattern detector, a generalisation of the fixed 1001 detector.
- Software loads a PAT_W-bit pattern, an overlap mode and a frame length.
- A start/busy/done handshake sequences one detection run over exactly cfg_len valid input bits.
- Each match is flagged on y as a registered, state-decoded Moore output, and matches are counted for readback.

Parameters:
PAT_W, 4, pattern length in bits (>=1); first-received bit compares to cfg_pattern[PAT_W-1]
CNT_W, 8, width of frame-length and match counters

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (reset==0 clears all state immediately)
cfg_we  in  1  latch cfg_pattern/cfg_overlap/cfg_len; honoured only in IDLE
cfg_pattern  in  PAT_W  target pattern, MSB = oldest bit
cfg_overlap  in  1  1 = overlapping matches allowed, 0 = history restarts after a match
cfg_len  in  CNT_W  number of valid bits per run
start  in  1  begin run; honoured only in IDLE
x  in  1  serial data bit
x_valid  in  1  x is consumed this cycle when high in RUN
busy  out  1  high in RUN
done  out  1  one-cycle pulse at run completion
y  out  1  one-cycle match pulse, registered
match_cnt  out  CNT_W  matches in current/last run

Behaviour:
- Reset (reset==0, async): state=IDLE. busy=0, done=0, y=0, match_cnt=0. Config regs clear: pattern=0, overlap=0, len=0. History and fill count clear.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cfg_we=1 loads config regs next edge.
  - start=1 with cfg_len!=0 -> RUN next edge. Same edge clears history, fill count, consumed count, match_cnt.
  - start=1 with cfg_len==0 -> DONE next edge, match_cnt=0.
  - cfg_we and start in the same cycle: config is loaded, and the run uses the newly loaded values.
- RUN:
  - busy=1. cfg_we and start are ignored.
  - Each cycle with x_valid=1: history <= {history[PAT_W-2:0], x}; fill <= min(fill+1, PAT_W); consumed++.
  - x_valid=0: no state change (gaps allowed).
- Match: next history == cfg_pattern and next fill == PAT_W. On that edge y<=1 for exactly one cycle, so y is high the cycle after the completing bit is presented. match_cnt++ on the same edge.
- Non-overlap mode (cfg_overlap=0): on a match, fill resets to 0, so the next match needs PAT_W fresh bits.
- Overlap mode (cfg_overlap=1): fill stays at PAT_W.
- End of frame: the edge consuming bit number cfg_len moves to DONE. A match on that final bit still pulses y, concurrent with done.
- DONE: busy=0, done=1 for one cycle, then IDLE unconditionally. start in DONE is ignored.
- match_cnt holds until the next accepted start. No overflow is possible because matches <= cfg_len <= 2^CNT_W-1.
- Reset asserted mid-run aborts immediately to the reset values, with no done pulse.

Test Plan:
- pattern=1001, overlap=1, len=7, bits 1,0,0,1,0,0,1 (x_valid=1 every cycle) -> y pulses the cycle after bit 4 and after bit 7; done on the cycle after bit 7 (coincident with the second y); match_cnt=2.
- Same stream with overlap=0 -> single y after bit 4; match_cnt=1; done after bit 7.
- pattern=1001, len=4, bits 1,0,0,1 with x_valid=0 idle cycles between bits -> busy stays high across gaps; y and done coincide after the 4th valid bit; match_cnt=1.
- Issue cfg_we with pattern=1111 and start during RUN -> both ignored; run completes with the original pattern and count. Then cfg_we+start together in IDLE -> new pattern used.
- len=0, start -> DONE on the next edge; done pulses one cycle; y never asserts; match_cnt=0; busy never high.
- Mid-run (after 3 bits), drive reset=0 between clock edges -> busy, y, match_cnt go 0 without waiting for a clock edge; no done; config regs clear.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
//   Run controller for a programmable serial Moore pattern detector.
//   Software loads a PAT_W-bit pattern, an overlap mode and a frame length,
//   then a start/busy/done handshake runs detection over exactly cfg_len
//   valid input bits. Matches pulse y (registered) and are counted.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   cfg_we       load cfg_pattern/cfg_overlap/cfg_len (IDLE only)
//   cfg_pattern  target pattern, MSB = oldest bit
//   cfg_overlap  1 = overlapping matches, 0 = history restarts after match
//   cfg_len      number of valid bits per run
//   start        begin a run (IDLE only)
//   x / x_valid  serial data bit and its qualifier
//   busy         high while running
//   done         one-cycle pulse at run completion
//   y            one-cycle registered match pulse
//   match_cnt    matches in current/last run
module seq_detect_ctrl #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             start,
  input  logic             x,
  input  logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [PAT_W-1:0]   r_pat;
  logic               r_ovl;
  logic [CNT_W-1:0]   r_len;
  logic [PAT_W-1:0]   r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic [CNT_W-1:0]   r_cons;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_y;

  logic [PAT_W-1:0]   w_hist_nxt;
  logic [FILL_W-1:0]  w_fill_inc;
  logic               w_match;
  logic               w_last;
  logic [CNT_W-1:0]   w_len_eff;

  always_comb begin
    // Shift form keeps PAT_W == 1 legal (no [PAT_W-2:0] slice)
    w_hist_nxt = (r_hist << 1) | PAT_W'(x);
    w_fill_inc = (r_fill == FILL_W'(PAT_W)) ? r_fill : r_fill + FILL_W'(1);
    w_match    = x_valid && (w_hist_nxt == r_pat) && (w_fill_inc == FILL_W'(PAT_W));
    w_last     = (r_cons + CNT_W'(1)) == r_len;
    // A start issued together with cfg_we uses the length being loaded
    w_len_eff  = cfg_we ? cfg_len : r_len;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_ovl   <= 1'b0;
      r_len   <= '0;
      r_hist  <= '0;
      r_fill  <= '0;
      r_cons  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_y     <= 1'b0;
    end else begin
      r_y    <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_we) begin
            r_pat <= cfg_pattern;
            r_ovl <= cfg_overlap;
            r_len <= cfg_len;
          end
          if (start) begin
            r_cnt <= '0;
            if (w_len_eff != '0) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_hist  <= '0;
              r_fill  <= '0;
              r_cons  <= '0;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (x_valid) begin
            r_hist <= w_hist_nxt;
            r_cons <= r_cons + CNT_W'(1);
            if (w_match) begin
              r_y    <= 1'b1;
              r_cnt  <= r_cnt + CNT_W'(1);
              r_fill <= r_ovl ? w_fill_inc : '0;
            end else begin
              r_fill <= w_fill_inc;
            end
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign y         = r_y;
  assign match_cnt = r_cnt;

endmodule
